// File: rtl/mem_port_16b_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_16b_pkg
//  Purpose  : Shared definitions for the 16-bit load/store unit. Holds the
//             FSM state encoding, the access-size codes and the widths of the
//             external byte bus.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_port_16b_pkg;

  // External bus geometry: 16-bit byte address, 8-bit data lane.
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  // Width of the internal load/store data word.
  localparam int WORD_W = 16;

  // Access-size codes carried on req_wide.
  localparam logic ACC_BYTE = 1'b0;
  localparam logic ACC_WORD = 1'b1;

  // Load/store sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage : mem_port_16b_pkg
`default_nettype wire

// File: rtl/mem_port_16b_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_16b_if
//  Purpose  : Bundles the request/response handshake with the sequencer and
//             the external 8-bit bus of the load/store unit.
//  Ports    : req_*  - access request from the sequencer
//             rsp_*  - completion pulse, error flag and load result
//             bus_*  - external byte bus (address, data, strobes, ack)
//  Modports : slave  - the load/store unit (serves requests, drives the bus)
//             master - the environment (sequencer plus external device)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_16b_if;
  import mem_port_16b_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_wide;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_err;
  logic [WORD_W-1:0] rsp_data;

  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rd;
  logic              bus_wr;
  logic              bus_ack;

  modport slave (
    input  req_valid, req_we, req_wide, req_addr, req_wdata,
    input  bus_rdata, bus_ack,
    output req_ready, rsp_valid, rsp_err, rsp_data,
    output bus_addr, bus_wdata, bus_rd, bus_wr
  );

  modport master (
    output req_valid, req_we, req_wide, req_addr, req_wdata,
    output bus_rdata, bus_ack,
    input  req_ready, rsp_valid, rsp_err, rsp_data,
    input  bus_addr, bus_wdata, bus_rd, bus_wr
  );

endinterface : mem_port_16b_if
`default_nettype wire

// File: rtl/mem_port_16b.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_16b
//  Purpose  : Load/store unit between the 16-bit ALU stage and the 8-bit
//             external bus. Byte or little-endian word accesses; a word is
//             split into two sequential byte cycles (addr, addr+1). Each byte
//             cycle waits for bus_ack, bounded by ACK_TIMEOUT cycles.
//  Params   : ACK_TIMEOUT - max wait cycles per byte before abort (0 = none)
//  Ports    : clk   - core clock, rising edge
//             rst_n - asynchronous active-low reset
//             mp    - request/response/bus bundle (slave view)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_16b
  import mem_port_16b_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mem_port_16b_if.slave    mp
);

  // Counter must be able to hold ACK_TIMEOUT itself; keep at least one bit.
  localparam int c_cnt_w = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_tmo = c_cnt_w'(ACK_TIMEOUT);

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_we;
  logic                r_wide;
  logic [DATA_W-1:0]   r_lo;
  logic [WORD_W-1:0]   r_rsp_data;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_err;

  logic                w_timeout;
  logic                w_active;

  // Abort condition for the current byte cycle; bus_ack always wins.
  assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == c_tmo);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mp.req_valid) begin
          w_next = ST_BYTE0;
        end
      end
      ST_BYTE0: begin
        if (mp.bus_ack) begin
          w_next = (r_wide == ACC_WORD) ? ST_BYTE1 : ST_RESP;
        end else if (w_timeout) begin
          w_next = ST_RESP;
        end
      end
      ST_BYTE1: begin
        if (mp.bus_ack || w_timeout) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, wait counter, read capture and response data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_wide     <= ACC_BYTE;
      r_lo       <= '0;
      r_rsp_data <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mp.req_valid) begin
            r_addr  <= mp.req_addr;
            r_wdata <= mp.req_wdata;
            r_we    <= mp.req_we;
            r_wide  <= mp.req_wide;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_BYTE0: begin
          if (mp.bus_ack) begin
            r_cnt <= '0;
            if (!r_we) begin
              r_lo <= mp.bus_rdata;
              // Byte loads finish here, so publish the zero-extended result.
              if (r_wide == ACC_BYTE) begin
                r_rsp_data <= {8'h00, mp.bus_rdata};
              end
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_BYTE1: begin
          if (mp.bus_ack) begin
            if (!r_we) begin
              r_rsp_data <= {mp.bus_rdata, r_lo};
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // ST_RESP: hold everything; rsp_data stays stable for the pulse.
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs: decoded from registered state only
  // --------------------------------------------------------------------------
  assign w_active     = (r_state == ST_BYTE0) || (r_state == ST_BYTE1);

  assign mp.req_ready = (r_state == ST_IDLE);
  // High byte of a word lives at addr+1; the 16-bit add wraps FFFF -> 0000.
  assign mp.bus_addr  = (r_state == ST_BYTE1) ? (r_addr + 16'd1) : r_addr;
  assign mp.bus_wdata = (r_state == ST_BYTE1) ? r_wdata[15:8] : r_wdata[7:0];
  assign mp.bus_rd    = w_active && !r_we;
  assign mp.bus_wr    = w_active &&  r_we;

  assign mp.rsp_valid = (r_state == ST_RESP);
  assign mp.rsp_err   = (r_state == ST_RESP) && r_err;
  assign mp.rsp_data  = r_rsp_data;

endmodule : mem_port_16b
`default_nettype wire

// File: tb/tb_mem_port_16b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_16b
//  Purpose  : Directed self-checking bench for mem_port_16b (ACK_TIMEOUT=4).
//             Inputs change 1 time unit after the rising edge; outputs are
//             checked at the same point, well away from the active edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_16b;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   n_rd;
  int   n_wr;
  int   n_rsp;
  int   b_rd;
  int   b_wr;
  int   b_rsp;

  mem_port_16b_if mp ();

  mem_port_16b #(
    .ACK_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mp    (mp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe cycles and response pulses mid-cycle.
  always @(negedge clk) begin
    if (mp.bus_rd === 1'b1)    n_rd  <= n_rd + 1;
    if (mp.bus_wr === 1'b1)    n_wr  <= n_wr + 1;
    if (mp.rsp_valid === 1'b1) n_rsp <= n_rsp + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge (accepted when idle).
  task automatic req(input logic we, input logic wide, input logic [15:0] addr,
                     input logic [15:0] wdata);
    mp.req_we    = we;
    mp.req_wide  = wide;
    mp.req_addr  = addr;
    mp.req_wdata = wdata;
    mp.req_valid = 1'b1;
    step();
    mp.req_valid = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    n_rd = 0; n_wr = 0; n_rsp = 0;
    rst_n = 1'b0;
    mp.req_valid = 1'b0; mp.req_we = 1'b0; mp.req_wide = 1'b0;
    mp.req_addr = '0; mp.req_wdata = '0;
    mp.bus_rdata = '0; mp.bus_ack = 1'b0;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_ready",  {31'd0, mp.req_ready}, 32'd1);
    check("rst_valid",  {31'd0, mp.rsp_valid}, 32'd0);
    check("rst_err",    {31'd0, mp.rsp_err},   32'd0);
    check("rst_data",   {16'd0, mp.rsp_data},  32'h0);
    check("rst_addr",   {16'd0, mp.bus_addr},  32'h0);
    check("rst_wdata",  {24'd0, mp.bus_wdata}, 32'h0);
    check("rst_rd",     {31'd0, mp.bus_rd},    32'd0);
    check("rst_wr",     {31'd0, mp.bus_wr},    32'd0);
    rst_n = 1'b1;
    step();

    // ---------------- byte load @1234 ----------------
    b_rd = n_rd; b_rsp = n_rsp;
    req(1'b0, 1'b0, 16'h1234, 16'h5A5A);
    check("bl_addr",  {16'd0, mp.bus_addr}, 32'h1234);
    check("bl_rd",    {31'd0, mp.bus_rd},   32'd1);
    check("bl_wr",    {31'd0, mp.bus_wr},   32'd0);
    check("bl_ready", {31'd0, mp.req_ready}, 32'd0);
    mp.bus_rdata = 8'hA5; mp.bus_ack = 1'b1;
    step();
    mp.bus_ack = 1'b0;
    check("bl_valid", {31'd0, mp.rsp_valid}, 32'd1);
    check("bl_err",   {31'd0, mp.rsp_err},   32'd0);
    check("bl_data",  {16'd0, mp.rsp_data},  32'h00A5);
    check("bl_rd_off",{31'd0, mp.bus_rd},    32'd0);
    step();
    check("bl_idle_valid", {31'd0, mp.rsp_valid}, 32'd0);
    check("bl_idle_ready", {31'd0, mp.req_ready}, 32'd1);
    check("bl_rd_cycles",  n_rd - b_rd,   32'd1);
    check("bl_rsp_count",  n_rsp - b_rsp, 32'd1);

    // ---------------- word load @FFFF (wrap) ----------------
    req(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    check("wl_addr0", {16'd0, mp.bus_addr}, 32'hFFFF);
    mp.bus_rdata = 8'h34; mp.bus_ack = 1'b1;
    step();
    check("wl_addr1", {16'd0, mp.bus_addr}, 32'h0000);
    check("wl_rd1",   {31'd0, mp.bus_rd},   32'd1);
    check("wl_valid_early", {31'd0, mp.rsp_valid}, 32'd0);
    mp.bus_rdata = 8'h12;
    step();
    mp.bus_ack = 1'b0;
    check("wl_valid", {31'd0, mp.rsp_valid}, 32'd1);
    check("wl_data",  {16'd0, mp.rsp_data},  32'h1234);
    step();

    // ---------------- word store @0200 with 2 waits per byte ----------------
    b_wr = n_wr;
    req(1'b1, 1'b1, 16'h0200, 16'hBEEF);
    check("ws_addr0",  {16'd0, mp.bus_addr},  32'h0200);
    check("ws_wdata0", {24'd0, mp.bus_wdata}, 32'hEF);
    check("ws_wr0",    {31'd0, mp.bus_wr},    32'd1);
    check("ws_rd0",    {31'd0, mp.bus_rd},    32'd0);
    step(); step();
    check("ws_wait0_addr", {16'd0, mp.bus_addr}, 32'h0200);
    mp.bus_ack = 1'b1;
    step();
    mp.bus_ack = 1'b0;
    check("ws_addr1",  {16'd0, mp.bus_addr},  32'h0201);
    check("ws_wdata1", {24'd0, mp.bus_wdata}, 32'hBE);
    check("ws_wr1",    {31'd0, mp.bus_wr},    32'd1);
    step(); step();
    check("ws_wait1_valid", {31'd0, mp.rsp_valid}, 32'd0);
    mp.bus_ack = 1'b1;
    step();
    mp.bus_ack = 1'b0;
    check("ws_valid", {31'd0, mp.rsp_valid}, 32'd1);
    check("ws_err",   {31'd0, mp.rsp_err},   32'd0);
    check("ws_data_kept", {16'd0, mp.rsp_data}, 32'h1234);
    check("ws_wr_cycles", n_wr - b_wr, 32'd6);
    step();

    // ---------------- timeout on byte load (T=4) ----------------
    b_rd = n_rd;
    req(1'b0, 1'b0, 16'h0050, 16'h0000);
    step(); step(); step(); step();
    check("to_rd_c5",    {31'd0, mp.bus_rd},    32'd1);
    check("to_valid_c5", {31'd0, mp.rsp_valid}, 32'd0);
    step();
    check("to_valid",  {31'd0, mp.rsp_valid}, 32'd1);
    check("to_err",    {31'd0, mp.rsp_err},   32'd1);
    check("to_data",   {16'd0, mp.rsp_data},  32'h1234);
    check("to_rd_off", {31'd0, mp.bus_rd},    32'd0);
    check("to_rd_cycles", n_rd - b_rd, 32'd5);
    step();
    check("to_ready",   {31'd0, mp.req_ready}, 32'd1);
    check("to_err_off", {31'd0, mp.rsp_err},   32'd0);

    // ---------------- timeout in high byte of word store ----------------
    b_wr = n_wr;
    req(1'b1, 1'b1, 16'h0300, 16'hCAFE);
    mp.bus_ack = 1'b1;
    step();
    mp.bus_ack = 1'b0;
    check("to1_addr",  {16'd0, mp.bus_addr},  32'h0301);
    check("to1_wdata", {24'd0, mp.bus_wdata}, 32'hCA);
    step(); step(); step(); step(); step();
    check("to1_valid", {31'd0, mp.rsp_valid}, 32'd1);
    check("to1_err",   {31'd0, mp.rsp_err},   32'd1);
    check("to1_wr_cycles", n_wr - b_wr, 32'd6);
    step();

    // ---------------- reset during BYTE1 of a word store ----------------
    req(1'b1, 1'b1, 16'h0400, 16'h1111);
    mp.bus_ack = 1'b1;
    step();
    mp.bus_ack = 1'b0;
    check("rm_wr_before", {31'd0, mp.bus_wr}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_wr",    {31'd0, mp.bus_wr},    32'd0);
    check("rm_ready", {31'd0, mp.req_ready}, 32'd1);
    check("rm_valid", {31'd0, mp.rsp_valid}, 32'd0);
    check("rm_data",  {16'd0, mp.rsp_data},  32'h0);
    check("rm_addr",  {16'd0, mp.bus_addr},  32'h0);
    check("rm_wdata", {24'd0, mp.bus_wdata}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    req(1'b1, 1'b0, 16'h0010, 16'h0077);
    check("pr_wdata", {24'd0, mp.bus_wdata}, 32'h77);
    check("pr_wr",    {31'd0, mp.bus_wr},    32'd1);
    mp.bus_ack = 1'b1;
    step();
    mp.bus_ack = 1'b0;
    check("pr_valid", {31'd0, mp.rsp_valid}, 32'd1);
    check("pr_err",   {31'd0, mp.rsp_err},   32'd0);
    check("pr_data",  {16'd0, mp.rsp_data},  32'h0);
    step();

    // ---------------- ignored req_valid while busy, spurious ack ----------------
    b_rd = n_rd; b_rsp = n_rsp;
    req(1'b0, 1'b0, 16'h0020, 16'h0000);
    mp.req_valid = 1'b1; mp.req_we = 1'b1; mp.req_addr = 16'h9999;
    step();
    check("ig_addr", {16'd0, mp.bus_addr}, 32'h0020);
    check("ig_rd",   {31'd0, mp.bus_rd},   32'd1);
    mp.req_valid = 1'b0;
    step();
    mp.req_valid = 1'b1;
    mp.bus_rdata = 8'h5C; mp.bus_ack = 1'b1;
    step();
    check("ig_valid", {31'd0, mp.rsp_valid}, 32'd1);
    check("ig_data",  {16'd0, mp.rsp_data},  32'h005C);
    step();
    mp.req_valid = 1'b0;
    step(); step(); step();
    mp.bus_ack = 1'b0;
    check("ig_ready",     {31'd0, mp.req_ready}, 32'd1);
    check("ig_rd_idle",   {31'd0, mp.bus_rd},    32'd0);
    check("ig_rd_cycles", n_rd - b_rd,   32'd3);
    check("ig_rsp_count", n_rsp - b_rsp, 32'd1);

    check("total_rsp", n_rsp, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_16b
`default_nettype wire

// File: doc/mem_port_16b.md
# mem_port_16b

Load/store unit sitting directly downstream of the 16-bit ALU/register-file stage. It takes the ALU's effective address (`mar_val`) and store data (`mem_data`) and performs byte or 16-bit little-endian accesses over the core's 8-bit external bus. Word accesses are split into two sequential byte cycles, with a bounded wait-for-acknowledge. Read results are returned as a 16-bit value that the sequencer steers back into the ALU's `t16` input.

## Interface
- `ACK_TIMEOUT`, default 255: maximum cycles a bus byte cycle waits for `bus_ack` before aborting; 0 disables the timeout.
- `clk` input 1: core clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: sequencer requests an access.
- `req_ready` output 1: unit is idle and accepts a request this cycle.
- `req_we` input 1: 1 = store, 0 = load.
- `req_wide` input 1: 1 = 16-bit access, 0 = 8-bit access.
- `req_addr` input 16: byte address, from `mar_val`.
- `req_wdata` input 16: store data, from `mem_data`; bits 7:0 only for byte stores.
- `rsp_valid` output 1: one-cycle pulse marking access completion (load or store).
- `rsp_err` output 1: qualifies `rsp_valid`; 1 = access aborted by timeout.
- `rsp_data` output 16: load result; byte loads are zero-extended.
- `bus_addr` output 16: external byte address.
- `bus_wdata` output 8: external write byte.
- `bus_rdata` input 8: external read byte, sampled when `bus_ack`=1.
- `bus_rd` output 1: read strobe, held for the whole byte cycle.
- `bus_wr` output 1: write strobe, held for the whole byte cycle.
- `bus_ack` input 1: external device completes the current byte cycle.

## Operation
- FSM states: IDLE, BYTE0, BYTE1, RESP.
- **IDLE**
  - `req_ready`=1; bus strobes low.
  - On `req_valid`: latch addr, we, wide and wdata; clear the wait counter; go to BYTE0.
- **BYTE0**
  - `bus_addr`=addr; `bus_wdata`=wdata[7:0]; `bus_rd`=~we; `bus_wr`=we.
  - On `bus_ack`:
    - Loads capture `bus_rdata` into data[7:0].
    - Byte access: go to RESP.
    - Wide access: clear the counter and go to BYTE1.
- **BYTE1**
  - `bus_addr`=addr+1 mod 2^16, so 16'hFFFF wraps to 16'h0000.
  - `bus_wdata`=wdata[15:8]; same strobes as BYTE0.
  - On `bus_ack`: loads capture data[15:8]; go to RESP.
- **RESP**
  - `rsp_valid`=1 for this cycle only; go to IDLE.
  - `rsp_data` is updated on entry to RESP for loads: byte = {8'h00, lo}; word = {hi, lo}.
  - Stores and errors leave `rsp_data` unchanged.
- **Timeout:** in BYTE0/BYTE1 the counter increments each cycle without `bus_ack`. If `ACK_TIMEOUT`≠0 and the counter reaches `ACK_TIMEOUT` with no ack, go to RESP with an error flag set; no further byte cycles are issued.
  - `rsp_err` = error flag during RESP, else 0.
  - A wide store aborted in BYTE1 leaves the low byte already written.
- **Ignored inputs:**
  - `req_valid` outside IDLE (sequencer must hold until `req_ready`).
  - `bus_ack` in IDLE/RESP.
- **Reset:** asynchronous; returns to IDLE mid-access with strobes dropped immediately.
  - `rsp_data`=0, `rsp_valid`=0, `rsp_err`=0, `req_ready`=1, `bus_addr`=0, `bus_wdata`=0, `bus_rd`=`bus_wr`=0.

## Timing
- Bus outputs and `req_ready` decode from registered state only (Moore); no combinational path from `bus_ack` or `req_valid` to any output.
- Request accepted at edge N (IDLE, `req_valid`=1) → BYTE0 during cycle N+1.
- Zero-wait byte access: `rsp_valid` in cycle N+2.
- Zero-wait word access: `rsp_valid` in cycle N+3.
- Each wait cycle (no ack) adds one cycle per byte.
- Back-to-back requests: next accept possible in the cycle after RESP. Throughput is one byte access per 3 cycles.
- Timeout: with `ACK_TIMEOUT`=T, a byte cycle lasts T+1 cycles at most before RESP.

## Structure
- Shared core package:
  - FSM state encoding (2-bit: IDLE=0, BYTE0=1, BYTE1=2, RESP=3).
  - Access-size constants (ACC_BYTE, ACC_WORD).
  - Bus address/data widths (16/8).
- Single module; no sub-module.
- The wait counter is sized to $clog2(`ACK_TIMEOUT`+1), minimum 1 bit.

## Test plan
- **Byte load:** addr 16'h1234, `bus_rdata` 8'hA5 with ack in first cycle → `bus_addr`=1234, `bus_rd`=1 for 1 cycle; `rsp_valid` at N+2; `rsp_data`=16'h00A5; `rsp_err`=0.
- **Word load at wrap:** addr 16'hFFFF, bytes 8'h34 then 8'h12 → `bus_addr` FFFF then 0000; `rsp_data`=16'h1234 at N+3.
- **Word store with waits:** addr 16'h0200, data 16'hBEEF, ack after 2 wait cycles each byte → `bus_wr` writes EF@0200 then BE@0201; `rsp_valid` at N+7; `rsp_data` unchanged.
- **Timeout:** `ACK_TIMEOUT`=4, no ack → strobe high 5 cycles; `rsp_valid`=1, `rsp_err`=1; return to IDLE with `req_ready`=1 the next cycle.
- **Reset mid-access:** assert `rst_n`=0 during BYTE1 of a word store → `bus_wr` drops asynchronously; all outputs at reset values; a new request after release completes normally.
- **Ignored inputs:** `req_valid` toggled while busy and spurious `bus_ack` in IDLE → no extra bus cycles; exactly one `rsp_valid` per accepted request.
